bcd_counter_multi: RTL and testbench
====================================

// Module: bcd_counter_multi
// PURPOSE
//   Parametrised multi-digit BCD counter: DIGITS cascaded decade stages, up/down
//   counting, synchronous clear and load, terminal-count and overflow flags.
//   Drives multi-digit 7-segment and timer displays in the lab designs.
//   Successor to the single-digit decade counter; one instance replaces a
//   carry-chained stack of single digits.
// PARAMETERS
//   DIGITS   4   number of BCD digits (>=1); count width = 4*DIGITS
// PORTS
//   clk       in   1          clock, rising edge
//   rst       in   1          reset, asynchronous, active-low
//   en        in   1          count enable, one step per clk while high
//   up_dn     in   1          1 = count up, 0 = count down
//   clr       in   1          synchronous clear to all-zero
//   load      in   1          synchronous load of load_val
//   load_val  in   4*DIGITS   value to load, digit i at bits [4i+3:4i]
//   count     out  4*DIGITS   current BCD value, digit 0 = least significant
//   tc        out  1          terminal count, combinational
//   ovf       out  1          registered 1-cycle pulse on wrap or saturation
//   load_err  out  1          registered 1-cycle pulse on a non-BCD load nibble
// BEHAVIOUR
//   - rst low: count=0, ovf=0, load_err=0 immediately, independent of clk.
//   - Priority per rising edge: clr > load > en. Hold when none asserted.
//   - clr: count<=0; ovf<=0; load_err<=0.
//   - load: digit i <= load_val nibble i if <=9, else 0.
//     load_err<=1 if any nibble >9, else 0. ovf<=0.
//   - en, up_dn=1: digit i steps iff every lower digit ==9.
//     Digit 9->0, other digits +1.
//   - en, up_dn=0: digit i steps iff every lower digit ==0.
//     Digit 0->9, other digits -1.
//   - Digit 0 always steps when en=1. All stepping digits update in the same
//     cycle. Latency: 1 clk from en to new count.
//   - tc = up_dn ? (all digits ==9) : (all digits ==0).
//     tc is independent of en, clr and load, so it can feed the en of a
//     further cascaded counter.
//   - ovf<=1 for exactly one cycle after an en step taken while tc=1.
//     Otherwise ovf<=0 on every clock.
//   - up_dn may change on any cycle; the step direction is sampled at that edge.
//   - clr or load in the same cycle as a terminal en step: clr/load wins, ovf<=0.
//   - rst asserted mid-count: outputs go to reset values at once. On release,
//     counting resumes from 0 at the first edge with en=1.
//   - Non-BCD digit values are unreachable: the load path sanitises them.
// CONFIGURATION
//   BCDC_SAT_EN defined:
//     - An en step with tc=1 leaves count unchanged: it holds at the all-9s
//       value up, or at 0 down.
//     - ovf still pulses 1 cycle per blocked step, so it repeats each cycle
//       while en stays high.
//   BCDC_SAT_EN undefined:
//     - Wrap-around: all-9s -> 0 up, 0 -> all-9s down. ovf pulses on the wrap.
// TESTING  (DIGITS=4 unless noted)
//   1 rst low mid-count at 0x0123 -> count=0x0000, ovf=0, load_err=0 before the next clk.
//      Release, en=1, up -> count=0x0001 after 1 clk.
//   2 load 0x0199, en=1, up, 2 clks -> 0x0200 then 0x0201; ovf stays 0; tc=0.
//   3 load 0x9999, up -> tc=1. One en clk -> count=0x0000, ovf=1 for 1 cycle.
//      With BCDC_SAT_EN: count=0x9999, ovf=1 each en cycle.
//   4 load 0x1000, down, en, 1 clk -> 0x0999. From 0x0000 down -> 0x9999, ovf=1.
//      With BCDC_SAT_EN: holds 0x0000.
//   5 load_val=0x12A4 with load=1 -> count=0x1204, load_err=1 for 1 cycle.
//      clr=1 together with load=1 and en=1 -> count=0x0000.
//   6 DIGITS=1: 10 up steps from 0 -> 1..9,0; tc=1 only at 9; ovf=1 only after 9->0.
//      Toggle up_dn at 5 -> next step 4.

Source files
------------

// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: parametrised multi-digit BCD up/down counter.
//
// DIGITS cascaded decade stages share one clock. All stepping digits update
// in the same cycle. Synchronous clear and load are provided. The counter
// reports terminal count and flags overflow and bad load values.
//
// Configuration macro: BCDC_SAT_EN
//   defined   - an en step taken at terminal count leaves count unchanged
//               (saturates), and ovf pulses for every blocked step
//   undefined - wrap-around: all-9s -> 0 counting up, 0 -> all-9s counting
//               down, and ovf pulses on the wrap
//
// Parameters
//   DIGITS    number of BCD digits (>=1); count width is 4*DIGITS
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active-low
//   en        count enable, one step per clock while high
//   up_dn     1 = count up, 0 = count down
//   clr       synchronous clear (highest priority)
//   load      synchronous load of load_val (beats en)
//   load_val  value to load, digit i at bits [4i+3:4i]
//   count     current BCD value, digit 0 least significant
//   tc        terminal count, combinational: all 9s up, all 0s down
//   ovf       registered 1-cycle pulse after an en step taken at tc
//   load_err  registered 1-cycle pulse after a load holding a nibble > 9
module bcd_counter_multi #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                ovf,
    output logic                load_err
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_san;
    logic                load_bad;
    logic                ovf_q, ovf_d;
    logic                load_err_q, load_err_d;
    logic                all9, all0;

    // Terminal-count detection over all digits.
    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            all9 = all9 & (count_q[4*i +: 4] == 4'd9);
            all0 = all0 & (count_q[4*i +: 4] == 4'd0);
        end
    end

    // tc is deliberately independent of en/clr/load so it can drive the en
    // of a further cascaded counter.
    assign tc = up_dn ? all9 : all0;

    // One step in the current direction. A digit steps only while every
    // lower digit sits at its roll-over value; digit 0 always steps.
    // Stepping from terminal count naturally wraps every digit.
    always_comb begin : p_step
        logic       ripple;
        logic [3:0] dig;
        step_val = count_q;
        ripple   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = count_q[4*i +: 4];
            if (ripple) begin
                if (up_dn) begin
                    step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                end else begin
                    step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                end
            end
            ripple = ripple & (up_dn ? (dig == 4'd9) : (dig == 4'd0));
        end
    end

    // Non-BCD load nibbles are forced to 0 so count never holds an illegal digit.
    always_comb begin
        load_san = '0;
        load_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_san[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Priority clr > load > en; ovf and load_err are pulses that default low.
    always_comb begin
        count_d    = count_q;
        ovf_d      = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d    = load_san;
            load_err_d = load_bad;
        end else if (en) begin
            ovf_d = tc;
`ifdef BCDC_SAT_EN
            if (!tc) begin
                count_d = step_val;
            end
`else
            count_d = step_val;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench for bcd_counter_multi: a DIGITS=4 instance and a
// DIGITS=1 instance. Each stimulus step pushes the expected result onto a
// scoreboard queue, computed by an integer-arithmetic reference model. The
// entry is popped and compared once the clock edge has produced output.
module tb_bcd_counter_multi;

    typedef struct packed {
        logic        e;
        logic        ud;
        logic        c;
        logic        l;
        logic [15:0] lv;
    } stim_t;

    typedef struct packed {
        logic [15:0] cnt;
        logic        ovf;
        logic        lerr;
        logic        tc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        en4 = 1'b0, ud4 = 1'b1, clr4 = 1'b0, load4 = 1'b0;
    logic [15:0] lv4 = '0;
    logic [15:0] count4;
    logic        tc4, ovf4, lerr4;

    logic        en1 = 1'b0, ud1 = 1'b1, clr1 = 1'b0, load1 = 1'b0;
    logic [3:0]  lv1 = '0;
    logic [3:0]  count1;
    logic        tc1, ovf1, lerr1;

    int checks = 0;
    int errors = 0;
    int mv4    = 0;
    int mv1    = 0;
    exp_t sb4[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    bcd_counter_multi #(.DIGITS(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .en       (en4),
        .up_dn    (ud4),
        .clr      (clr4),
        .load     (load4),
        .load_val (lv4),
        .count    (count4),
        .tc       (tc4),
        .ovf      (ovf4),
        .load_err (lerr4)
    );

    bcd_counter_multi #(.DIGITS(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en1),
        .up_dn    (ud1),
        .clr      (clr1),
        .load     (load1),
        .load_val (lv1),
        .count    (count1),
        .tc       (tc1),
        .ovf      (ovf1),
        .load_err (lerr1)
    );

    function automatic stim_t mk(input logic e, input logic ud, input logic c, input logic l,
                                 input logic [15:0] lv);
        return stim_t'{e, ud, c, l, lv};
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference model on the decimal value of the counter.
    task automatic model(input stim_t s, input int nd, inout int mv, output exp_t x);
        int         mx;
        logic [3:0] nib;
        mx = 10 ** nd - 1;
        x  = '0;
        if (s.c) begin
            mv = 0;
        end else if (s.l) begin
            mv = 0;
            for (int i = 0; i < nd; i++) begin
                nib = s.lv[4*i +: 4];
                if (nib > 4'd9) begin
                    x.lerr = 1'b1;
                    nib    = 4'd0;
                end
                mv = mv + int'(nib) * (10 ** i);
            end
        end else if (s.e) begin
            if (s.ud ? (mv == mx) : (mv == 0)) begin
                x.ovf = 1'b1;
`ifndef BCDC_SAT_EN
                mv = s.ud ? 0 : mx;
`endif
            end else begin
                mv = s.ud ? mv + 1 : mv - 1;
            end
        end
        x.cnt = to_bcd(mv);
        x.tc  = s.ud ? (mv == mx) : (mv == 0);
    endtask

    task automatic drive4(input stim_t s);
        exp_t x;
        @(negedge clk);
        en4 = s.e; ud4 = s.ud; clr4 = s.c; load4 = s.l; lv4 = s.lv;
        model(s, 4, mv4, x);
        sb4.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input stim_t s);
        exp_t x;
        @(negedge clk);
        en1 = s.e; ud1 = s.ud; clr1 = s.c; load1 = s.l; lv1 = s.lv[3:0];
        model(s, 1, mv1, x);
        sb1.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        drive4(mk(0, 1, 0, 1, 16'h0123));
        x = sb4.pop_front();
        checks++;
        if ({count4, ovf4, lerr4, tc4} !== {x.cnt, x.ovf, x.lerr, x.tc}) begin
            errors++;
            $display("FAIL reset_preload: count=%h ovf=%b load_err=%b tc=%b, expected %h %b %b %b",
                     count4, ovf4, lerr4, tc4, x.cnt, x.ovf, x.lerr, x.tc);
        end
        // Assert reset away from any rising edge; outputs must clear at once.
        @(negedge clk);
        en4 = 0; clr4 = 0; load4 = 0;
        rst = 1'b0;
        #1;
        checks++;
        if (count4 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async_count: count=%h, expected 0000", count4);
        end
        checks++;
        if ({ovf4, lerr4} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async_flags: ovf=%b load_err=%b, expected 0 0", ovf4, lerr4);
        end
        #2;
        rst = 1'b1;
        mv4 = 0;
        mv1 = 0;
        drive4(mk(1, 1, 0, 0, 16'h0));
        x = sb4.pop_front();
        checks++;
        if ({count4, ovf4, lerr4, tc4} !== {x.cnt, x.ovf, x.lerr, x.tc}) begin
            errors++;
            $display("FAIL reset_resume: count=%h ovf=%b load_err=%b tc=%b, expected %h %b %b %b",
                     count4, ovf4, lerr4, tc4, x.cnt, x.ovf, x.lerr, x.tc);
        end
    endtask

    task automatic run4(input string name, input stim_t st[$]);
        exp_t x;
        for (int k = 0; k < st.size(); k++) begin
            drive4(st[k]);
            x = sb4.pop_front();
            checks++;
            if ({count4, ovf4, lerr4, tc4} !== {x.cnt, x.ovf, x.lerr, x.tc}) begin
                errors++;
                $display("FAIL %s step %0d: count=%h ovf=%b load_err=%b tc=%b, expected %h %b %b %b",
                         name, k, count4, ovf4, lerr4, tc4, x.cnt, x.ovf, x.lerr, x.tc);
            end
        end
    endtask

    task automatic test_carry();
        stim_t st[$];
        st = '{mk(0, 1, 0, 1, 16'h0199), mk(1, 1, 0, 0, 0), mk(1, 1, 0, 0, 0),
               mk(0, 1, 0, 0, 0)};
        run4("carry", st);
    endtask

    task automatic test_wrap_up();
        stim_t st[$];
        st = '{mk(0, 1, 0, 1, 16'h9999), mk(1, 1, 0, 0, 0), mk(1, 1, 0, 0, 0),
               mk(0, 1, 0, 0, 0), mk(0, 0, 0, 1, 16'h9999), mk(0, 1, 0, 0, 0)};
        run4("wrap_up", st);
    endtask

    task automatic test_down();
        stim_t st[$];
        st = '{mk(0, 0, 0, 1, 16'h1000), mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0),
               mk(0, 0, 0, 1, 16'h0000), mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0),
               mk(1, 1, 0, 0, 0)};
        run4("down", st);
    endtask

    task automatic test_load_err();
        stim_t st[$];
        st = '{mk(0, 1, 0, 1, 16'h12A4), mk(0, 1, 0, 0, 0), mk(0, 1, 0, 1, 16'hF9B7),
               mk(1, 1, 1, 1, 16'h4321), mk(0, 1, 0, 1, 16'h9999), mk(1, 1, 1, 0, 0),
               mk(0, 1, 0, 1, 16'h9999), mk(1, 1, 0, 1, 16'h0042)};
        run4("load_clr", st);
    endtask

    task automatic test_digits1();
        stim_t st[$];
        exp_t  x;
        st = '{mk(0, 1, 1, 0, 0)};
        for (int k = 0; k < 10; k++) st.push_back(mk(1, 1, 0, 0, 0));
        for (int k = 0; k < 5; k++) st.push_back(mk(1, 1, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0));
        st.push_back(mk(0, 0, 0, 1, 16'h000C));
        for (int k = 0; k < st.size(); k++) begin
            drive1(st[k]);
            x = sb1.pop_front();
            checks++;
            if ({count1, ovf1, lerr1, tc1} !== {x.cnt[3:0], x.ovf, x.lerr, x.tc}) begin
                errors++;
                $display("FAIL digits1 step %0d: count=%h ovf=%b load_err=%b tc=%b, expected %h %b %b %b",
                         k, count1, ovf1, lerr1, tc1, x.cnt[3:0], x.ovf, x.lerr, x.tc);
            end
        end
        @(negedge clk);
        en1 = 0; clr1 = 0; load1 = 0;
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        logic [15:0] lv;
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 3))
                0:       lv = 16'h9998;
                1:       lv = 16'h0001;
                default: lv = 16'($urandom);
            endcase
            st.push_back(mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0), lv));
        end
        run4("back_to_back", st);
    endtask

    initial begin
        #12;
        rst = 1'b1;
        test_reset();
        test_carry();
        test_wrap_up();
        test_down();
        test_load_err();
        test_digits1();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
